// File: rtl/audio_attr_scanram.sv
// Voice attribute RAM with byte-wide host writes and a handshaked sequential voice scanner.
// Optional word-clear sequencer enabled by defining AUDIO_ATTR_CLEAR_EN.
module audio_attr_scanram #(
    parameter int unsigned NUM_VOICES = 16,
    parameter int unsigned WORD_BYTES = 4,
    localparam int unsigned VW = $clog2(NUM_VOICES),
    localparam int unsigned BW = $clog2(WORD_BYTES),
    localparam int unsigned HW = VW + BW,
    localparam int unsigned DW = WORD_BYTES * 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          wr_en_i,
    input  logic [HW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic          scan_start_i,
    input  logic          scan_ready_i,
`ifdef AUDIO_ATTR_CLEAR_EN
    input  logic          clear_i,
`endif
    output logic          scan_valid_o,
    output logic [VW-1:0] scan_voice_o,
    output logic [DW-1:0] scan_data_o,
    output logic          scan_busy_o,
    output logic          scan_done_o
);

    localparam int unsigned LW = (BW > 0) ? BW : 1;
    localparam logic [VW-1:0] LAST_VOICE = VW'(NUM_VOICES - 1);

`ifdef AUDIO_ATTR_CLEAR_EN
    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;
`endif

    state_t        state_q, state_d;
    logic [VW-1:0] cnt_q, cnt_d;
    logic [VW-1:0] voice_d;
    logic [DW-1:0] data_d;
    logic          valid_d, busy_d, done_d;
    logic          rd_en, clr_we;
    logic [DW-1:0] rd_data;
    logic [VW-1:0] wr_voice;
    logic [LW-1:0] wr_lane;

    // Contents survive reset; power-up value is all zero.
    logic [DW-1:0] mem [NUM_VOICES] = '{default: '0};

    if (BW == 0) begin : g_single_lane
        assign wr_lane  = '0;
        assign wr_voice = wr_addr_i;
    end else begin : g_multi_lane
        assign wr_lane  = wr_addr_i[BW-1:0];
        assign wr_voice = wr_addr_i[HW-1:BW];
    end

    // Storage and read-first registered read port.
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem[cnt_q] <= '0;
        end else if (wr_en_i) begin
            for (int b = 0; b < int'(WORD_BYTES); b++) begin
                if (wr_lane == LW'(b)) begin
                    mem[wr_voice][b*8 +: 8] <= wr_data_i;
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[cnt_d];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            scan_valid_o <= 1'b0;
            scan_voice_o <= '0;
            scan_data_o  <= '0;
            scan_busy_o  <= 1'b0;
            scan_done_o  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            scan_valid_o <= valid_d;
            scan_voice_o <= voice_d;
            scan_data_o  <= data_d;
            scan_busy_o  <= busy_d;
            scan_done_o  <= done_d;
        end
    end

    // The done cycle still counts as busy, so a start there is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = scan_valid_o;
        voice_d = scan_voice_o;
        data_d  = scan_data_o;
        done_d  = 1'b0;
        rd_en   = 1'b0;
        clr_we  = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef AUDIO_ATTR_CLEAR_EN
                if (clear_i && !scan_done_o) begin
                    cnt_d   = '0;
                    state_d = CLEAR;
                end else
`endif
                if (scan_start_i && !scan_done_o) begin
                    cnt_d   = '0;
                    rd_en   = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                data_d  = rd_data;
                voice_d = cnt_q;
                valid_d = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (scan_ready_i) begin
                    valid_d = 1'b0;
                    if (cnt_q == LAST_VOICE) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + VW'(1);
                        rd_en   = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
`ifdef AUDIO_ATTR_CLEAR_EN
            CLEAR: begin
                clr_we = 1'b1;
                if (cnt_q == LAST_VOICE) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + VW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || done_d;
    end

endmodule
